// File: rtl/frame_aligner_param.sv
// Byte-stream frame aligner: hunts for a two-byte header (pair A or B),
// tracks position in fixed-length frames, declares lock/loss and re-times
// the stream so only frames from locked periods are delivered with SOF/EOF.
module frame_aligner_param #(
  parameter int unsigned FRAME_LEN   = 12,
  parameter int unsigned LOCK_FRAMES = 3,
  parameter int unsigned LOSS_BYTES  = 48,
  parameter logic [7:0]  HDR_A_LSB   = 8'hAA,
  parameter logic [7:0]  HDR_A_MSB   = 8'hAF,
  parameter logic [7:0]  HDR_B_LSB   = 8'h55,
  parameter logic [7:0]  HDR_B_MSB   = 8'hBA,
  localparam int unsigned POS_W      = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_sof,
  output logic             out_eof,
  output logic [POS_W-1:0] fr_byte_position,
  output logic             hdr_type,
  output logic             frame_detect,
  output logic [7:0]       hdr_err_cnt
);

  localparam int unsigned GW = $clog2(LOCK_FRAMES + 1);
  localparam int unsigned NW = $clog2(LOSS_BYTES + 1);

  typedef enum logic [1:0] {HUNT, HMSB, DATA} state_t;

  state_t           state, state_nxt;
  logic [POS_W-1:0] pos, pos_nxt;
  logic             pair_b, pair_nxt;
  logic [GW-1:0]    good_cnt, good_nxt, good_inc;
  logic [NW-1:0]    na_cnt, na_nxt, na_inc;
  logic             expect_hdr, expect_nxt;
  logic             hmsb_exp, hmsb_exp_nxt;
  logic             hdr_err, lock_evt, loss_evt, deliver;
  logic             is_lsb, lsb_b;
  logic [7:0]       exp_msb;
  logic [7:0]       d1;
  logic [POS_W-1:0] out_pos_inc;

  assign is_lsb   = (rx_data == HDR_A_LSB) || (rx_data == HDR_B_LSB);
  assign lsb_b    = (rx_data == HDR_B_LSB) && (rx_data != HDR_A_LSB);
  assign exp_msb  = pair_b ? HDR_B_MSB : HDR_A_MSB;
  assign good_inc = (good_cnt == GW'(LOCK_FRAMES)) ? good_cnt : good_cnt + 1'b1;
  assign na_inc   = (na_cnt == NW'(LOSS_BYTES)) ? na_cnt : na_cnt + 1'b1;
  assign loss_evt = (na_nxt == NW'(LOSS_BYTES));
  assign out_pos_inc = fr_byte_position + 1'b1;

  // Next-state, counter updates and header-error / lock / delivery decisions
  always_comb begin
    state_nxt    = state;
    pos_nxt      = pos;
    pair_nxt     = pair_b;
    good_nxt     = good_cnt;
    na_nxt       = na_cnt;
    expect_nxt   = 1'b0;
    hmsb_exp_nxt = hmsb_exp;
    hdr_err      = 1'b0;
    lock_evt     = 1'b0;
    deliver      = 1'b0;
    case (state)
      HUNT: begin
        if (is_lsb) begin
          pair_nxt     = lsb_b;
          hmsb_exp_nxt = expect_hdr;
          state_nxt    = HMSB;
        end else begin
          na_nxt   = na_inc;
          good_nxt = '0;
          hdr_err  = expect_hdr;
        end
      end
      HMSB: begin
        if (rx_data == exp_msb) begin
          good_nxt  = good_inc;
          na_nxt    = '0;
          state_nxt = DATA;
          pos_nxt   = POS_W'(2);
          lock_evt  = (good_inc == GW'(LOCK_FRAMES));
          deliver   = frame_detect || lock_evt;
        end else if (is_lsb) begin
          // overlap recovery: this LSB becomes the new header candidate,
          // which was not itself at an expected header slot
          pair_nxt     = lsb_b;
          na_nxt       = na_inc;
          hdr_err      = hmsb_exp;
          hmsb_exp_nxt = 1'b0;
        end else begin
          good_nxt  = '0;
          na_nxt    = na_inc;
          state_nxt = HUNT;
          hdr_err   = hmsb_exp;
        end
      end
      DATA: begin
        if (pos == POS_W'(FRAME_LEN - 1)) begin
          state_nxt  = HUNT;
          expect_nxt = 1'b1;
        end else begin
          pos_nxt = pos + 1'b1;
        end
      end
      default: state_nxt = HUNT;
    endcase
  end

  // Alignment state, counters, lock indication and header-error count
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= HUNT;
      pos          <= '0;
      pair_b       <= 1'b0;
      good_cnt     <= '0;
      na_cnt       <= '0;
      expect_hdr   <= 1'b0;
      hmsb_exp     <= 1'b0;
      frame_detect <= 1'b0;
      hdr_err_cnt  <= '0;
    end else begin
      state      <= state_nxt;
      pos        <= pos_nxt;
      pair_b     <= pair_nxt;
      good_cnt   <= good_nxt;
      na_cnt     <= na_nxt;
      expect_hdr <= expect_nxt;
      hmsb_exp   <= hmsb_exp_nxt;
      if (lock_evt)
        frame_detect <= 1'b1;
      else if (loss_evt)
        frame_detect <= 1'b0;
      if (hdr_err && frame_detect && (hdr_err_cnt != '1))
        hdr_err_cnt <= hdr_err_cnt + 1'b1;
    end
  end

  // Two-stage data pipe plus delivered-frame framing; the delivery decision
  // is made on the MSB byte, which lines up with the LSB leaving the pipe
  always_ff @(posedge clk) begin
    if (reset) begin
      d1               <= '0;
      out_data         <= '0;
      out_valid        <= 1'b0;
      out_sof          <= 1'b0;
      out_eof          <= 1'b0;
      fr_byte_position <= '0;
      hdr_type         <= 1'b0;
    end else begin
      d1       <= rx_data;
      out_data <= d1;
      if (deliver) begin
        out_valid        <= 1'b1;
        out_sof          <= 1'b1;
        out_eof          <= 1'b0;
        fr_byte_position <= '0;
        hdr_type         <= pair_b;
      end else if (out_valid && (fr_byte_position != POS_W'(FRAME_LEN - 1))) begin
        out_valid        <= 1'b1;
        out_sof          <= 1'b0;
        out_eof          <= (out_pos_inc == POS_W'(FRAME_LEN - 1));
        fr_byte_position <= out_pos_inc;
      end else begin
        out_valid        <= 1'b0;
        out_sof          <= 1'b0;
        out_eof          <= 1'b0;
        fr_byte_position <= '0;
        hdr_type         <= 1'b0;
      end
    end
  end

endmodule

// File: doc/frame_aligner_param.md
# frame_aligner_param

Parametrised byte-stream frame aligner for the receive path, sitting directly after the byte deserialiser. It hunts for a two-byte header (one of two configurable header pairs), tracks byte position inside fixed-length frames, and declares lock after a configurable run of good headers. It declares loss after a configurable run of unaligned bytes. Unlike the previous aligner, it re-times the stream and delivers only frames from locked periods with SOF/EOF framing, recovers from overlapping header bytes, and counts header errors while locked.

## Interface
- FRAME_LEN, 12: bytes per frame including 2 header bytes; legal range 4..256
- LOCK_FRAMES, 3: consecutive good headers required to assert frame_detect; legal range 1..15
- LOSS_BYTES, 48: consecutive unaligned bytes that clear frame_detect; legal range 2..255
- HDR_A_LSB / HDR_A_MSB, 8'hAA / 8'hAF: header pair A (LSB byte arrives first)
- HDR_B_LSB / HDR_B_MSB, 8'h55 / 8'hBA: header pair B
- POS_W (localparam), $clog2(FRAME_LEN): position width
- clk  in  1  sole clock, rising edge
- reset  in  1  synchronous, active-high
- rx_data  in  8  one received byte per cycle, always valid
- out_data  out  8  rx_data delayed 2 cycles
- out_valid  out  1  out_data belongs to a delivered frame
- out_sof  out  1  out_data is header LSB of a delivered frame
- out_eof  out  1  out_data is byte FRAME_LEN-1 of a delivered frame
- fr_byte_position  out  POS_W  position of out_data in its frame; 0 when not in a frame
- hdr_type  out  1  0 = pair A, 1 = pair B; valid while out_valid
- frame_detect  out  1  alignment lock indication
- hdr_err_cnt  out  8  saturating count of header misses while locked

## Operation
- FSM states: HUNT, HMSB, DATA. Reset state is HUNT.
- HUNT:
  - rx_data equal to either LSB pattern: record the pair, go to HMSB.
  - Otherwise: na_cnt+1 (saturating at LOSS_BYTES) and good_cnt <= 0.
- HMSB:
  - rx_data equals the recorded pair's MSB: good_cnt+1 (saturating at LOCK_FRAMES), na_cnt <= 0, go to DATA at position 2.
  - Otherwise, rx_data is an LSB pattern: re-record the pair and stay in HMSB (overlap recovery, e.g. AA AA AF aligns on the second AA); na_cnt+1.
  - Otherwise: good_cnt <= 0, na_cnt+1, go to HUNT.
- DATA:
  - Position increments by 1 per byte.
  - At position FRAME_LEN-1, go to HUNT and set expect_hdr for one cycle.
- Header error while frame_detect=1 increments hdr_err_cnt (saturates at 255, cleared only by reset). A header error is either:
  - the byte in HUNT with expect_hdr set is not an LSB pattern, or
  - an MSB mismatch in HMSB that was entered with expect_hdr.
- frame_detect:
  - Set in the cycle after good_cnt reaches LOCK_FRAMES.
  - Cleared in the cycle after na_cnt reaches LOSS_BYTES.
  - Set has priority if both occur.
- Delivery: a frame is delivered if, in its MSB-header cycle, frame_detect=1 or that header brings good_cnt to LOCK_FRAMES.
  - A delivered frame produces exactly FRAME_LEN consecutive out_valid cycles.
  - out_sof is asserted on the first of these cycles and out_eof on the last.
  - hdr_type is constant for the whole frame.
- Frames not delivered: out_valid, out_sof and out_eof stay 0; out_data still follows rx_data.
- Loss mid-frame does not truncate a frame already being delivered.

## Timing
- Latency from rx_data to out_data / out_valid / out_sof / out_eof / fr_byte_position / hdr_type is exactly 2 cycles; all outputs are registered.
- frame_detect rises 1 cycle after the MSB header byte that completes the lock count. In that cycle out_sof of the locking frame is asserted: the locking frame is delivered.
- Back-to-back frames: the header LSB directly follows byte FRAME_LEN-1 with no idle bytes, and out_valid stays high across the boundary.
- Reset, applied at any time including mid-frame:
  - On the next edge all outputs are 0, the FSM is in HUNT, and good_cnt, na_cnt, expect_hdr and hdr_err_cnt are 0.
  - Any in-flight partial frame is discarded and no out_eof is emitted for it.
  - The 2-stage data pipe is also cleared to 0.
- Counter widths are sized to hold their saturation values, with no wrap-around.

## Test plan
- 3 back-to-back A frames (AA AF + 10 data bytes) → frame_detect rises 1 cycle after the 3rd AF. Third frame: out_sof 2 cycles after its AA, out_eof 11 cycles after that, fr_byte_position 0..11. Frames 1–2 are not delivered.
- Locked on pair B (55 BA), then 48 bytes of 00 → frame_detect falls 1 cycle after the 48th 00. hdr_err_cnt = 1, from the first missing header.
- Stream AA AA AF then data → alignment on the second AA; the delivered frame's out_sof is on the second AA; hdr_type = 0.
- Locked, then one frame whose header is AA 00 followed by valid frames → hdr_err_cnt increments by 1. good_cnt restarts; frame_detect stays 1 (na_cnt < 48). Following valid frames are delivered.
- Reset asserted at position 6 of a delivered frame → next cycle all outputs 0 and no out_eof. Then 3 good frames are needed to relock.
- 300 locked frames with a corrupted header every frame → hdr_err_cnt saturates at 255.
